// File: rtl/low_latency_10g_1ch_rst_pkg.sv
// Shared types and defaults for the single-channel 10G PLL/PHY reset sequencer.
// Holds the sequencer state encoding, event-count width and parameter defaults.
package low_latency_10g_1ch_rst_pkg;

  localparam int CNT_W                   = 8;
  localparam int DEF_RST_HOLD_CYCLES     = 64;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_SYNC_STAGES         = 2;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    TX_REL,
    RX_REL,
    READY
  } seq_state_t;

  typedef logic [CNT_W-1:0] evt_cnt_t;

endpackage

// File: rtl/low_latency_10g_1ch_bit_sync.sv
// Multi-flop synchronizer for a single level signal crossing into the local clock.
// All stages clear synchronously so no stale lock level survives a reset.
module low_latency_10g_1ch_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/low_latency_10g_1ch_pll_rst_seq.sv
// Reset sequencer for a 10G PHY channel: pulses the PLL reset, waits for stable lock,
// then releases TX and RX digital resets in turn, re-sequencing on any lock loss.
module low_latency_10g_1ch_pll_rst_seq
  import low_latency_10g_1ch_rst_pkg::*;
#(
  parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             tx_digitalreset,
  output logic             rx_digitalreset,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int MAX_A   = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES
                                                                   : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  // Sized to hold the largest load value itself, not just values below it.
  localparam int TMR_W   = $clog2(MAX_CYC + 1);
  localparam int SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [TMR_W-1:0] HOLD_LD    = TMR_W'(RST_HOLD_CYCLES);
  localparam logic [TMR_W-1:0] STABLE_LD  = TMR_W'(LOCK_STABLE_CYCLES);
  localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);

  function automatic evt_cnt_t sat_inc(input evt_cnt_t v);
    return (v == '1) ? v : v + evt_cnt_t'(1);
  endfunction

  logic             locked_s;
  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic             tmr_done;
  logic             loss_evt;
  logic             timeout_evt;

  low_latency_10g_1ch_bit_sync #(
    .STAGES(SYNC_N)
  ) u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (pll_locked),
    .q  (locked_s)
  );

  // Lock loss is tested ahead of timer expiry in every state that watches lock.
  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr - TMR_ONE;
    tmr_done    = (tmr == TMR_ONE);
    loss_evt    = 1'b0;
    timeout_evt = 1'b0;
    case (state)
      PLL_RST: begin
        if (tmr_done) begin
          state_nxt = WAIT_LOCK;
          tmr_nxt   = TIMEOUT_LD;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
          tmr_nxt   = STABLE_LD;
        end else if (tmr_done) begin
          state_nxt   = PLL_RST;
          tmr_nxt     = HOLD_LD;
          timeout_evt = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          tmr_nxt   = TIMEOUT_LD;
        end else if (tmr_done) begin
          state_nxt = TX_REL;
          tmr_nxt   = HOLD_LD;
        end
      end
      TX_REL: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          tmr_nxt   = TIMEOUT_LD;
        end else if (tmr_done) begin
          state_nxt = RX_REL;
          tmr_nxt   = HOLD_LD;
        end
      end
      RX_REL: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          tmr_nxt   = TIMEOUT_LD;
        end else if (tmr_done) begin
          state_nxt = READY;
          tmr_nxt   = HOLD_LD;
        end
      end
      READY: begin
        tmr_nxt = tmr;
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          tmr_nxt   = TIMEOUT_LD;
          loss_evt  = 1'b1;
        end
      end
      default: begin
        state_nxt = PLL_RST;
        tmr_nxt   = HOLD_LD;
      end
    endcase
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state           <= PLL_RST;
      tmr             <= HOLD_LD;
      pll_rst         <= 1'b1;
      tx_digitalreset <= 1'b1;
      rx_digitalreset <= 1'b1;
      ready           <= 1'b0;
      lock_loss_cnt   <= '0;
      timeout_cnt     <= '0;
    end else begin
      state           <= state_nxt;
      tmr             <= tmr_nxt;
      pll_rst         <= (state_nxt == PLL_RST);
      tx_digitalreset <= (state_nxt inside {PLL_RST, WAIT_LOCK, STABLE});
      rx_digitalreset <= !(state_nxt inside {RX_REL, READY});
      ready           <= (state_nxt == READY);
      if (timeout_evt) begin
        timeout_cnt <= sat_inc(timeout_cnt);
      end
      if (loss_evt) begin
        lock_loss_cnt <= sat_inc(lock_loss_cnt);
      end
    end
  end

endmodule

// File: tb/tb_low_latency_10g_1ch_pll_rst_seq.sv
// Bench for the 10G PLL reset sequencer: directed bring-up/timeout/glitch/loss scenarios
// followed by randomized lock and reset activity, all scored against a phase model.
module tb_low_latency_10g_1ch_pll_rst_seq;

  localparam int HOLD = 4;
  localparam int STB  = 8;
  localparam int TMO  = 32;
  localparam int SYNC = 2;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       tx_digitalreset;
  logic       rx_digitalreset;
  logic       ready;
  logic [7:0] lock_loss_cnt;
  logic [7:0] timeout_cnt;

  int checks = 0;
  int errors = 0;

  // Phase model: 0 pll reset, 1 wait lock, 2 stable, 3 tx release, 4 rx release, 5 ready.
  int   m_ph;
  int   m_el;
  int   m_lc;
  int   m_tc;
  logic m_sync[SYNC];

  always #5 refclk = ~refclk;

  low_latency_10g_1ch_pll_rst_seq #(
    .RST_HOLD_CYCLES    (HOLD),
    .LOCK_STABLE_CYCLES (STB),
    .LOCK_TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES        (SYNC)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .pll_rst        (pll_rst),
    .tx_digitalreset(tx_digitalreset),
    .rx_digitalreset(rx_digitalreset),
    .ready          (ready),
    .lock_loss_cnt  (lock_loss_cnt),
    .timeout_cnt    (timeout_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic ls;
    if (rst) begin
      m_ph = 0;
      m_el = 0;
      m_lc = 0;
      m_tc = 0;
      for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    end else begin
      ls = m_sync[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = pll_locked;
      m_el++;
      case (m_ph)
        0: if (m_el == HOLD) begin m_ph = 1; m_el = 0; end
        1: begin
          if (ls) begin
            m_ph = 2; m_el = 0;
          end else if (m_el == TMO) begin
            m_ph = 0; m_el = 0;
            if (m_tc < 255) m_tc++;
          end
        end
        2: begin
          if (!ls) begin m_ph = 1; m_el = 0; end
          else if (m_el == STB) begin m_ph = 3; m_el = 0; end
        end
        3, 4: begin
          if (!ls) begin m_ph = 1; m_el = 0; end
          else if (m_el == HOLD) begin m_ph = m_ph + 1; m_el = 0; end
        end
        default: begin
          if (!ls) begin
            m_ph = 1; m_el = 0;
            if (m_lc < 255) m_lc++;
          end
        end
      endcase
    end
  endtask

  task automatic tick();
    logic [3:0] exp_ctl;
    @(posedge refclk);
    model_step();
    #1;
    exp_ctl = {m_ph == 0, m_ph < 3, m_ph < 4, m_ph == 5};
    chk("ctl", {pll_rst, tx_digitalreset, rx_digitalreset, ready}, exp_ctl);
    chk("lock_loss_cnt", lock_loss_cnt, m_lc);
    chk("timeout_cnt", timeout_cnt, m_tc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ctl", {pll_rst, tx_digitalreset, rx_digitalreset, ready}, 4'b1110);
    chk("rst_cnt", {lock_loss_cnt, timeout_cnt}, 0);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input logic lvl, input int bound, output int n);
    n = 0;
    while (ready !== lvl && n < bound) begin
      tick();
      n++;
    end
    if (ready !== lvl) chk("wait_ready_bound", ready, lvl);
  endtask

  initial begin
    int n;
    int tx_at;
    int run;
    rst        = 1'b1;
    pll_locked = 1'b0;
    do_reset();

    // Clean bring-up
    repeat (10) tick();
    pll_locked = 1'b1;
    n = 0;
    tx_at = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (tx_digitalreset === 1'b0 && tx_at == 0) tx_at = n;
    end
    chk("tx_rel_lat", tx_at, 11);
    chk("ready_lat", n, 19);
    chk("bringup_cnt", {lock_loss_cnt, timeout_cnt}, 0);

    // Lock loss while READY, then relock
    pll_locked = 1'b0;
    wait_ready(1'b0, 20, n);
    chk("loss_lat", n, 3);
    chk("loss_rst", {tx_digitalreset, rx_digitalreset}, 2'b11);
    chk("loss_cnt", lock_loss_cnt, 1);
    pll_locked = 1'b1;
    wait_ready(1'b1, 200, n);
    chk("relock_lat", n, 19);

    // Lock-wait timeouts
    pll_locked = 1'b0;
    do_reset();
    for (int k = 1; k <= 108; k++) begin
      tick();
      if (k % 36 == 0) begin
        chk("to_prst_hi", pll_rst, 1);
        chk("to_cnt", timeout_cnt, k / 36);
      end
      if (k == 35 || k == 40 || k == 107) chk("to_prst_lo", pll_rst, 0);
      if (k == 39) chk("to_pulse_len", pll_rst, 1);
    end
    chk("to_ready", ready, 0);

    // One-cycle glitch during STABLE
    do_reset();
    repeat (6) tick();
    pll_locked = 1'b1;
    n = 0;
    while (m_ph != 2 && n < 50) begin tick(); n++; end
    chk("reach_stable", m_ph, 2);
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_ready(1'b1, 200, n);
    chk("glitch_relock", n, 19);
    chk("glitch_loss_cnt", lock_loss_cnt, 0);

    // Repeated READY losses saturate the loss count
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      wait_ready(1'b0, 10, n);
      pll_locked = 1'b1;
      wait_ready(1'b1, 60, n);
    end
    chk("sat_loss_cnt", lock_loss_cnt, 255);

    // Reset asserted mid RX release
    pll_locked = 1'b0;
    wait_ready(1'b0, 10, n);
    pll_locked = 1'b1;
    n = 0;
    while (m_ph != 4 && n < 60) begin tick(); n++; end
    chk("reach_rx_rel", m_ph, 4);
    rst = 1'b1;
    tick();
    chk("mid_rst_ctl", {pll_rst, tx_digitalreset, rx_digitalreset, ready}, 4'b1110);
    chk("mid_rst_cnt", {lock_loss_cnt, timeout_cnt}, 0);
    rst = 1'b0;

    // Randomized lock activity with occasional resets
    run = 0;
    for (int k = 0; k < 3000; k++) begin
      if (run == 0) begin
        pll_locked = 1'($urandom_range(0, 1));
        run = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 45);
      end
      run--;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
